// File: rtl/mode_transition_controller_pkg.sv
// rtl/mode_transition_controller_pkg.sv - shared mode codes, FSM states and default masks
package mode_transition_controller_pkg;

    localparam int STAND_MODE  = 0;
    localparam int FIRST_MODE  = 1;
    localparam int SECOND_MODE = 2;
    localparam int THIRD_MODE  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_FIRE    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    // Mask bit [from*NUM_MODES+to]
    localparam logic [15:0] DEFAULT_DIRECT_MASK = 16'h0240;
    localparam logic [15:0] DEFAULT_ARMED_MASK  = 16'h510E;
    localparam logic [3:0]  DEFAULT_ONCE_MASK   = 4'b1000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mode_ctrl_timer.sv
// rtl/mode_ctrl_timer.sv - loadable saturating down-counter with zero flag
module mode_ctrl_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/mode_transition_controller.sv
// rtl/mode_transition_controller.sv - arms, validates and fires one-hot mode toggles
// with lockout, arming timeout and once-per-session targets.
module mode_transition_controller
    import mode_transition_controller_pkg::*;
#(
    parameter int NUM_MODES      = 4,
    parameter int MODE_WIDTH     = 2,
    parameter int HOME_MODE      = STAND_MODE,
    parameter logic [NUM_MODES*NUM_MODES-1:0] DIRECT_MASK = DEFAULT_DIRECT_MASK,
    parameter logic [NUM_MODES*NUM_MODES-1:0] ARMED_MASK  = DEFAULT_ARMED_MASK,
    parameter logic [NUM_MODES-1:0]           ONCE_MASK   = DEFAULT_ONCE_MASK,
    parameter int ARM_TIMEOUT    = 8,
    parameter int LOCKOUT_CYCLES = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [MODE_WIDTH-1:0] current_mode_i,
    input  logic                  menu_signal_i,
    input  logic [NUM_MODES-1:0]  mode_sel_i,
    output logic [NUM_MODES-1:0]  mode_toggle_o,
    output logic [MODE_WIDTH-1:0] target_mode_o,
    output logic                  armed_o,
    output logic                  lockout_o,
    output logic                  arm_timeout_o,
    output logic                  reject_o
);

    localparam int NSQ       = NUM_MODES * NUM_MODES;
    localparam int TW        = (max3(ARM_TIMEOUT, LOCKOUT_CYCLES, 2) > 2) ?
                               $clog2(max3(ARM_TIMEOUT, LOCKOUT_CYCLES, 2)) : 1;
    localparam int LOCK_LOAD = (LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0;

    state_t                state_q, state_d;
    logic [NUM_MODES-1:0]  toggle_q, toggle_d, used_q, used_d;
    logic [MODE_WIDTH-1:0] target_q, target_d, mode_q;
    logic                  armed_q, lockout_q, arm_to_q, arm_to_d, reject_q, reject_d;
    logic                  timer_load, timer_en, timer_zero;
    logic [TW-1:0]         timer_load_val;

    logic                  sel_any, win_used, legal_base, direct_hit, armed_hit;
    logic [MODE_WIDTH-1:0] win_idx;
    int                    shamt;

    // Lowest set select wins; a discarded winner does not fall through to the next bit
    always_comb begin
        win_idx  = '0;
        win_used = 1'b0;
        for (int i = NUM_MODES - 1; i >= 0; i--) begin
            if (mode_sel_i[i]) begin
                win_idx  = MODE_WIDTH'(i);
                win_used = used_q[i];
            end
        end
        sel_any    = |mode_sel_i;
        shamt      = int'(current_mode_i) * NUM_MODES + int'(win_idx);
        legal_base = sel_any && (int'(current_mode_i) < NUM_MODES) &&
                     (win_idx != current_mode_i) && !win_used;
        direct_hit = legal_base && |(DIRECT_MASK & (NSQ'(1) << shamt));
        armed_hit  = legal_base && |(ARMED_MASK & (NSQ'(1) << shamt));
    end

    always_comb begin
        state_d        = state_q;
        toggle_d       = '0;
        target_d       = target_q;
        arm_to_d       = 1'b0;
        reject_d       = 1'b0;
        used_d         = used_q;
        timer_load     = 1'b0;
        timer_load_val = TW'(ARM_TIMEOUT - 1);
        timer_en       = 1'b0;

        if ((state_q != ST_FIRE) && (current_mode_i == MODE_WIDTH'(HOME_MODE))) begin
            used_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (direct_hit) begin
                    state_d  = ST_FIRE;
                    toggle_d = NUM_MODES'(1) << win_idx;
                    target_d = win_idx;
                end else begin
                    reject_d = sel_any;
                    if (menu_signal_i) begin
                        state_d    = ST_ARMED;
                        timer_load = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (current_mode_i != mode_q) begin
                    state_d = ST_IDLE;
                end else if (direct_hit || armed_hit) begin
                    state_d  = ST_FIRE;
                    toggle_d = NUM_MODES'(1) << win_idx;
                    target_d = win_idx;
                end else begin
                    reject_d = sel_any;
                    if (menu_signal_i) begin
                        state_d = ST_IDLE;
                    end else if (timer_zero) begin
                        state_d  = ST_IDLE;
                        arm_to_d = 1'b1;
                    end else begin
                        timer_en = 1'b1;
                    end
                end
            end
            ST_FIRE: begin
                for (int i = 0; i < NUM_MODES; i++) begin
                    if ((target_q == MODE_WIDTH'(i)) && ONCE_MASK[i]) begin
                        used_d[i] = 1'b1;
                    end
                end
                if (LOCKOUT_CYCLES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d        = ST_LOCKOUT;
                    timer_load     = 1'b1;
                    timer_load_val = TW'(LOCK_LOAD);
                end
            end
            default: begin
                if (timer_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_en = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            toggle_q  <= '0;
            target_q  <= MODE_WIDTH'(HOME_MODE);
            used_q    <= '0;
            mode_q    <= '0;
            armed_q   <= 1'b0;
            lockout_q <= 1'b0;
            arm_to_q  <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            toggle_q  <= toggle_d;
            target_q  <= target_d;
            used_q    <= used_d;
            mode_q    <= current_mode_i;
            armed_q   <= (state_d == ST_ARMED);
            lockout_q <= (state_d == ST_LOCKOUT);
            arm_to_q  <= arm_to_d;
            reject_q  <= reject_d;
        end
    end

    mode_ctrl_timer #(.WIDTH(TW)) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (timer_load),
        .load_val_i (timer_load_val),
        .en_i       (timer_en),
        .zero_o     (timer_zero)
    );

    assign mode_toggle_o = toggle_q;
    assign target_mode_o = target_q;
    assign armed_o       = armed_q;
    assign lockout_o     = lockout_q;
    assign arm_timeout_o = arm_to_q;
    assign reject_o      = reject_q;

endmodule
